led_controller: RTL and testbench
=================================

LED_CONTROLLER -- requirements
Module: led_controller

Interface
REQ-001 Parameter LED_COUNT, default `LED_NUM, number of LED outputs (>= 1).
REQ-002 Parameter LED_ADDR, default `LED_MEM, data-memory address of the word for LED index 0.
REQ-003 Parameter ADDR_WIDTH, default `DATA_ADDR_WIDTH, data-memory address width.
REQ-004 Parameter LED_COUNT_WIDTH, default `LED_NUM_WIDTH, width of the LED index.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; 0 resets, 1 runs.
REQ-007 copy_start  input  1  request to read the LED words from data memory.
REQ-008 mem_din_re  output  1  read enable to data memory.
REQ-009 mem_din_addr  output  ADDR_WIDTH  read address to data memory.
REQ-010 mem_din  input  16  read data, valid the cycle after the address is issued.
REQ-011 leds_out  output  LED_COUNT  registered LED drive levels.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a new LED image is committed.

Function
REQ-014 FSM states SHALL be IDLE, READ, DRAIN and COMMIT.
REQ-015 IDLE SHALL go to READ on a rising edge with copy_start=1, and SHALL stay in IDLE otherwise.
REQ-016 In READ, mem_din_re SHALL be 1 and mem_din_addr SHALL take the values LED_ADDR+k, k=0..LED_COUNT-1, one per cycle.
REQ-017 READ SHALL go to DRAIN after the cycle that issues LED_ADDR+LED_COUNT-1.
REQ-018 DRAIN SHALL last one cycle with mem_din_re=0, then go to COMMIT.
REQ-019 COMMIT SHALL last one cycle with done=1, then go to IDLE.
REQ-020 mem_din_re SHALL be 0 in IDLE, DRAIN and COMMIT.
REQ-021 mem_din_addr SHALL hold LED_ADDR in IDLE and SHALL hold its last value in DRAIN and COMMIT.
REQ-022 A one-cycle-delayed valid bit and index SHALL capture mem_din into shadow bit [LED_COUNT-1-k] for the word read from LED_ADDR+k.
REQ-023 A shadow bit SHALL be 1 if its 16-bit word is nonzero, and 0 otherwise.
REQ-024 On the edge leaving DRAIN, leds_out SHALL load the complete shadow image, including the final word captured on that same edge.
REQ-025 The update SHALL be atomic: leds_out keeps its previous value through IDLE, READ and DRAIN, with no partial updates.
REQ-026 copy_start SHALL be ignored whenever busy=1 and SHALL NOT be queued.
REQ-027 copy_start=1 in the COMMIT cycle SHALL be ignored; IDLE is always entered first.
REQ-028 With copy_start held high, a new transfer SHALL begin on the first edge in IDLE.
REQ-029 Latency SHALL be fixed: sampled copy_start edge to done=1 is LED_COUNT+2 cycles, and busy is high for LED_COUNT+2 cycles.
REQ-030 For LED_COUNT=1, READ SHALL last one cycle.
REQ-031 Address arithmetic SHALL be ADDR_WIDTH bits, and the index SHALL be LED_COUNT_WIDTH bits.
REQ-032 The highest index used SHALL be LED_COUNT-1; the index SHALL never go out of range.

Reset
REQ-033 While reset=0, asynchronously: state=IDLE, leds_out=0, shadow=0, busy=0, done=0, mem_din_re=0, mem_din_addr=LED_ADDR, delayed valid=0.
REQ-034 Reset during READ or DRAIN SHALL abort the transfer, SHALL leave leds_out=0 and SHALL NOT pulse done.
REQ-035 After reset is released, the first transfer SHALL need a fresh copy_start sampled in IDLE.

Verification
REQ-036 LED_COUNT=4, memory words 0x0001,0x0000,0x8000,0x0000, one copy_start pulse: addresses LED_ADDR..+3 issued, then leds_out=4'b1010 with done=1 exactly 6 cycles after the copy_start edge.
REQ-037 Same setup, copy_start pulsed again in READ cycle 2 and in COMMIT: exactly one done pulse; busy high for 6 cycles; no extra reads.
REQ-038 leds_out=4'b1111 from a prior transfer, then all words 0: leds_out stays 4'b1111 through DRAIN and becomes 4'b0000 on COMMIT entry.
REQ-039 reset asserted in READ cycle 2, without waiting for a clock: leds_out=0, mem_din_re=0, busy=0 at once; no done after release.
REQ-040 copy_start held high for 20 cycles, LED_COUNT=4: back-to-back transfers, done every 7 cycles, IDLE visited one cycle between transfers.
REQ-041 LED_COUNT=1, word 0x0100: one read cycle; leds_out=1'b1 and done=1 three cycles after copy_start.

Source files
------------

// File: rtl/led_controller.sv
// LED image loader: reads LED_COUNT words from data memory, reduces each word to one
// LED bit, and commits the whole image to leds_out in a single cycle.
`ifndef LED_NUM
`define LED_NUM 8
`endif
`ifndef LED_NUM_WIDTH
`define LED_NUM_WIDTH 3
`endif
`ifndef LED_MEM
`define LED_MEM 12'h100
`endif
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 12
`endif

module led_controller #(
    parameter int LED_COUNT       = `LED_NUM,
    parameter int LED_ADDR        = `LED_MEM,
    parameter int ADDR_WIDTH      = `DATA_ADDR_WIDTH,
    parameter int LED_COUNT_WIDTH = `LED_NUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  copy_start,
    output logic                  mem_din_re,
    output logic [ADDR_WIDTH-1:0] mem_din_addr,
    input  logic [15:0]           mem_din,
    output logic [LED_COUNT-1:0]  leds_out,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        COMMIT
    } state_e;

    localparam logic [ADDR_WIDTH-1:0]      LED_BASE = ADDR_WIDTH'(LED_ADDR);
    localparam logic [ADDR_WIDTH-1:0]      ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LED_COUNT_WIDTH-1:0] LAST_IDX = LED_COUNT_WIDTH'(LED_COUNT - 1);
    localparam logic [LED_COUNT_WIDTH-1:0] IDX_ONE  = LED_COUNT_WIDTH'(1);

    state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [LED_COUNT_WIDTH-1:0] idx_q, idx_d;
    logic                       rd_vld_q;
    logic [LED_COUNT_WIDTH-1:0] rd_idx_q;
    logic [LED_COUNT-1:0]       shadow_q, shadow_d;
    logic [LED_COUNT-1:0]       leds_q, leds_d;

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                addr_d = LED_BASE;
                idx_d  = '0;
                if (copy_start) state_d = READ;
            end
            READ: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d  = idx_q + IDX_ONE;
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            DRAIN: state_d = COMMIT;
            COMMIT: begin
                state_d = IDLE;
                addr_d  = LED_BASE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Word k lands in bit LED_COUNT-1-k; the final word is merged here so the commit sees it.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < LED_COUNT; i++) begin
            if (rd_vld_q && (rd_idx_q == LED_COUNT_WIDTH'(LED_COUNT - 1 - i))) begin
                shadow_d[i] = |mem_din;
            end
        end
        leds_d = (state_q == DRAIN) ? shadow_d : leds_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    // NOTE: the small shadow register is reset too, since a stale image must never reach the LEDs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= LED_BASE;
            idx_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
            shadow_q <= '0;
            leds_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            rd_vld_q <= (state_q == READ);
            rd_idx_q <= idx_q;
            shadow_q <= shadow_d;
            leds_q   <= leds_d;
        end
    end

    assign mem_din_re   = (state_q == READ);
    assign mem_din_addr = addr_q;
    assign leds_out     = leds_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == COMMIT);

endmodule

// File: tb/tb_led_controller.sv
// Self-checking bench for led_controller: a 4-LED and a 1-LED instance share one
// synchronous memory model; expectations come from the word-to-bit rule and cycle arithmetic.
`timescale 1ns/1ps
module tb_led_controller;

    localparam int N4 = 4;
    localparam int N1 = 1;
    localparam int AW = 8;
    localparam int A4 = 64;
    localparam int A1 = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cs4, re4, busy4, done4;
    logic [AW-1:0] addr4;
    logic [15:0]   din4;
    logic [N4-1:0] leds4;
    logic          cs1, re1, busy1, done1;
    logic [AW-1:0] addr1;
    logic [15:0]   din1;
    logic [N1-1:0] leds1;

    logic [15:0] mem [0:255];
    int reads4 = 0;
    int reads1 = 0;
    int passed = 0;
    int total  = 0;
    logic [N4-1:0] exp_leds4 = '0;
    logic [N1-1:0] exp_leds1 = '0;

    led_controller #(.LED_COUNT(N4), .LED_ADDR(A4), .ADDR_WIDTH(AW), .LED_COUNT_WIDTH(2)) dut4 (
        .clk(clk), .reset(reset), .copy_start(cs4), .mem_din_re(re4), .mem_din_addr(addr4),
        .mem_din(din4), .leds_out(leds4), .busy(busy4), .done(done4));

    led_controller #(.LED_COUNT(N1), .LED_ADDR(A1), .ADDR_WIDTH(AW), .LED_COUNT_WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .copy_start(cs1), .mem_din_re(re1), .mem_din_addr(addr1),
        .mem_din(din1), .leds_out(leds1), .busy(busy1), .done(done1));

    // Synchronous-read memory; returns junk when not enabled so stray captures show up.
    always @(posedge clk) begin
        din4 <= re4 ? mem[addr4] : 16'($urandom);
        din1 <= re1 ? mem[addr1] : 16'($urandom);
        if (re4) reads4 <= reads4 + 1;
        if (re1) reads1 <= reads1 + 1;
    end

    function automatic logic [N4-1:0] model4();
        logic [N4-1:0] r;
        for (int k = 0; k < N4; k++) r[N4-1-k] = (mem[A4+k] != 16'h0);
        return r;
    endfunction

    function automatic logic [15:0] rand_word();
        case ($urandom_range(0, 2))
            0:       return 16'h0000;
            1:       return 16'(32'h1 << $urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    // One transfer on the 4-LED instance, checked every cycle from the sampled edge.
    task automatic xfer4(input bit extra, input string tag);
        logic [N4-1:0] new_leds;
        logic [14:0]   got, exp;
        int            r0;
        new_leds = model4();
        r0 = reads4;
        cs4 = 1'b1;
        @(negedge clk);
        cs4 = 1'b0;
        for (int c = 1; c <= N4 + 2; c++) begin
            exp = {1'b1, 1'(c <= N4), 1'(c == N4 + 2),
                   8'(A4 + ((c <= N4) ? c - 1 : N4 - 1)),
                   (c == N4 + 2) ? new_leds : exp_leds4};
            got = {busy4, re4, done4, addr4, leds4};
            total++;
            if (got !== exp) $display("FAIL %s cycle%0d {busy,re,done,addr,leds} got %h exp %h", tag, c, got, exp);
            else passed++;
            cs4 = extra && (c == 2 || c == N4 + 2);
            @(negedge clk);
        end
        cs4 = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 8'(A4), new_leds};
        got = {busy4, re4, done4, addr4, leds4};
        total++;
        if (got !== exp) $display("FAIL %s idle {busy,re,done,addr,leds} got %h exp %h", tag, got, exp);
        else passed++;
        @(negedge clk);
        total++;
        if (busy4 !== 1'b0) $display("FAIL %s not_queued busy got %b exp 0", tag, busy4);
        else passed++;
        total++;
        if (reads4 - r0 != N4) $display("FAIL %s reads got %0d exp %0d", tag, reads4 - r0, N4);
        else passed++;
        exp_leds4 = new_leds;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cs4 = 1'b0;
        cs1 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy4, re4, done4, addr4, leds4} !== {3'b000, 8'(A4), 4'b0000})
            $display("FAIL reset4 got %h exp %h", {busy4, re4, done4, addr4, leds4}, {3'b000, 8'(A4), 4'b0000});
        else passed++;
        total++;
        if ({busy1, re1, done1, addr1, leds1} !== {3'b000, 8'(A1), 1'b0})
            $display("FAIL reset1 got %h exp %h", {busy1, re1, done1, addr1, leds1}, {3'b000, 8'(A1), 1'b0});
        else passed++;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy4, busy1, leds4, leds1} !== 7'b0)
            $display("FAIL reset_release_idle got %b exp 0", {busy4, busy1, leds4, leds1});
        else passed++;
    endtask

    task automatic test_directed();
        mem[A4+0] = 16'h0001;
        mem[A4+1] = 16'h0000;
        mem[A4+2] = 16'h8000;
        mem[A4+3] = 16'h0000;
        xfer4(1'b0, "directed");
        total++;
        if (leds4 !== 4'b1010) $display("FAIL directed_image got %b exp 1010", leds4);
        else passed++;
        xfer4(1'b1, "ignore_start");
    endtask

    task automatic test_atomic();
        for (int k = 0; k < N4; k++) mem[A4+k] = 16'h0400;
        xfer4(1'b0, "all_ones");
        for (int k = 0; k < N4; k++) mem[A4+k] = 16'h0000;
        xfer4(1'b0, "atomic_zero");
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < N4; k++) mem[A4+k] = rand_word();
            xfer4(1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        for (int k = 0; k < N4; k++) mem[A4+k] = 16'h0001;
        xfer4(1'b0, "abort_prep");
        for (int k = 0; k < N4; k++) mem[A4+k] = 16'h0000;
        cs4 = 1'b1;
        @(negedge clk);
        cs4 = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        total++;
        if ({leds4, re4, busy4, done4} !== 7'b0)
            $display("FAIL abort_async {leds,re,busy,done} got %b exp 0", {leds4, re4, busy4, done4});
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done4 || busy4) dones++;
        end
        total++;
        if (dones != 0 || leds4 !== 4'b0) $display("FAIL abort_after active_cycles got %0d leds %b exp 0 0000", dones, leds4);
        else passed++;
        exp_leds4 = '0;
    endtask

    task automatic test_back_to_back();
        bit busy_exp [0:31];
        bit done_exp [0:31];
        int next_free, ndone, r0, bad;
        for (int c = 0; c < 32; c++) begin
            busy_exp[c] = 1'b0;
            done_exp[c] = 1'b0;
        end
        next_free = 1;
        for (int s = 1; s <= 26; s++) begin
            if (s <= 20 && s >= next_free) begin
                for (int j = 0; j <= N4 + 1; j++) busy_exp[s+j] = 1'b1;
                done_exp[s+N4+1] = 1'b1;
                next_free = s + N4 + 3;
            end
        end
        for (int k = 0; k < N4; k++) mem[A4+k] = rand_word();
        r0 = reads4;
        ndone = 0;
        bad = 0;
        cs4 = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 26; c++) begin
            if (busy4 !== busy_exp[c] || done4 !== done_exp[c]) begin
                bad++;
                $display("FAIL b2b cycle%0d {busy,done} got %b%b exp %b%b", c, busy4, done4, busy_exp[c], done_exp[c]);
            end
            if (done4 === 1'b1) ndone++;
            if (c == 20) cs4 = 1'b0;
            @(negedge clk);
        end
        total++;
        if (bad != 0) $display("FAIL b2b_timeline errors got %0d exp 0", bad);
        else passed++;
        total++;
        if (ndone != 3) $display("FAIL b2b_done_count got %0d exp 3", ndone);
        else passed++;
        total++;
        if (reads4 - r0 != 3 * N4) $display("FAIL b2b_reads got %0d exp %0d", reads4 - r0, 3 * N4);
        else passed++;
        exp_leds4 = model4();
        total++;
        if (leds4 !== exp_leds4) $display("FAIL b2b_image got %b exp %b", leds4, exp_leds4);
        else passed++;
    endtask

    task automatic test_single_led();
        logic [N1-1:0] new_led;
        logic [3:0]    got, exp;
        for (int t = 0; t < 4; t++) begin
            mem[A1] = (t == 0) ? 16'h0100 : rand_word();
            new_led = (mem[A1] != 16'h0);
            cs1 = 1'b1;
            @(negedge clk);
            cs1 = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                exp = {1'(c <= 3), 1'(c == 1), 1'(c == 3), (c >= 3) ? new_led : exp_leds1};
                got = {busy1, re1, done1, leds1};
                total++;
                if (got !== exp) $display("FAIL single t%0d cycle%0d {busy,re,done,leds} got %b exp %b", t, c, got, exp);
                else passed++;
                @(negedge clk);
            end
            exp_leds1 = new_led;
        end
        total++;
        if (reads1 != 4) $display("FAIL single_reads got %0d exp 4", reads1);
        else passed++;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        test_reset();
        test_directed();
        test_atomic();
        test_random();
        test_reset_abort();
        test_back_to_back();
        test_single_led();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
